// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code view and a one-entry
// valid/ready output stage; load overrides stepping, and wrap flags modular roll-over.
module gray_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             en_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_reg,  bin_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             valid_reg, valid_next;
  logic             wrap_reg,  wrap_next;
  logic             step;

  // The output stage can take a new value when empty or being drained this cycle.
  assign en_ready = !valid_reg || out_ready;
  assign step     = en && en_ready && !load;

  always_comb begin
    bin_next   = bin_reg;
    valid_next = valid_reg;
    wrap_next  = wrap_reg;
    if (load) begin
      bin_next   = load_val;
      valid_next = 1'b1;
      wrap_next  = 1'b0;
    end else if (step) begin
      valid_next = 1'b1;
      if (up_dn) begin
        bin_next  = bin_reg + ONE;
        wrap_next = (bin_reg == ALL_ONES);
      end else begin
        bin_next  = bin_reg - ONE;
        wrap_next = (bin_reg == ALL_ZERO);
      end
    end else if (valid_reg && out_ready) begin
      valid_next = 1'b0;
      wrap_next  = 1'b0;
    end else if (!valid_reg) begin
      wrap_next = 1'b0;
    end
    // Stalled (valid && !ready): everything above keeps its held value.
  end

  // Gray code is derived from the next binary value so both registers update together.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
    end
  endgenerate
  assign gray_next[WIDTH-1] = bin_next[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg   <= ALL_ZERO;
      gray_reg  <= ALL_ZERO;
      valid_reg <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      bin_reg   <= bin_next;
      gray_reg  <= gray_next;
      valid_reg <= valid_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign bin_out   = bin_reg;
  assign gray_out  = gray_reg;
  assign out_valid = valid_reg;
  assign wrap      = wrap_reg;

endmodule
